// File: rtl/audio_pkg.sv
// Shared constants for the codec audio path (playback and capture).
//
// Contents:
//   XCK_HZ               master clock frequency the defaults are tuned for
//   BCK_HALF_DEFAULT     XCK cycles per BCK half-period (BCK = XCK/12)
//   BITS_PER_CH_DEFAULT  BCK slots per channel, also the sample width
//   SLOTS_PER_FRAME      BCK slots per LRCK frame
//   lrck_e               LRCK polarity (LEFT = 0)
//   bck_hz()             helper that derives the bit clock rate
package audio_pkg;

  localparam int unsigned XCK_HZ              = 18_432_000;
  localparam int          BCK_HALF_DEFAULT    = 6;
  localparam int          BITS_PER_CH_DEFAULT = 16;
  localparam int          SLOTS_PER_FRAME     = 2 * BITS_PER_CH_DEFAULT;

  typedef enum logic {
    LRCK_LEFT  = 1'b0,
    LRCK_RIGHT = 1'b1
  } lrck_e;

  function automatic int unsigned bck_hz(input int unsigned bck_half);
    return XCK_HZ / (2 * bck_half);
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// I2S bit/word clock generator, entirely in the AUD_XCK domain.
// BCK and LRCK are plain registers toggled by clock-enable events, so no
// derived clock ever reaches a clock pin.
//
// Ports:
//   AUD_XCK   in   master clock
//   reset     in   asynchronous active-high reset
//   bck       out  bit clock (register)
//   lrck      out  word clock, slot_cnt MSB half (0 = left)
//   fall_evt  out  one-XCK strobe on the cycle BCK falls
//   slot_cnt  out  current BCK slot within the frame
module i2s_clkgen
  import audio_pkg::*;
#(
  parameter int BCK_HALF    = BCK_HALF_DEFAULT,
  parameter int BITS_PER_CH = BITS_PER_CH_DEFAULT,
  localparam int SLOTS      = 2 * BITS_PER_CH,
  localparam int SLOT_W     = $clog2(SLOTS)
) (
  input  logic              AUD_XCK,
  input  logic              reset,
  output logic              bck,
  output logic              lrck,
  output logic              fall_evt,
  output logic [SLOT_W-1:0] slot_cnt
);

  localparam int DIV_W = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;

  logic [DIV_W-1:0]  div_cnt;
  logic              div_wrap;
  logic [SLOT_W-1:0] slot_next;

  assign div_wrap  = (div_cnt == DIV_W'(BCK_HALF - 1));
  // The wrap that takes BCK from high to low is the fall event; data and
  // counters move here so the codec samples stable data on the next rise.
  assign fall_evt  = div_wrap && bck;
  assign slot_next = (slot_cnt == SLOT_W'(SLOTS - 1)) ? '0
                                                      : slot_cnt + SLOT_W'(1);

  // NOTE: state registers use non-blocking assignments so every update in
  // this block sees the values from before the clock edge.
  always_ff @(posedge AUD_XCK or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      bck      <= 1'b0;
      slot_cnt <= '0;
      lrck     <= LRCK_LEFT;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
      if (div_wrap) begin
        bck <= !bck;
      end
      if (fall_evt) begin
        slot_cnt <= slot_next;
        lrck     <= (slot_next < SLOT_W'(BITS_PER_CH)) ? LRCK_LEFT : LRCK_RIGHT;
      end
    end
  end

endmodule

// File: rtl/i2s_audioout.sv
// I2S transmitter toward the codec DAC.
// Accepts stereo sample pairs over valid/ready into a one-deep holding
// register, loads a frame shift register at every frame boundary and
// serialises {left, right} MSB-first on AUD_DACDAT. When no new pair is
// waiting at a boundary, the previous frame is repeated and underrun pulses.
//
// Ports:
//   AUD_XCK       in   master clock, the only clock
//   reset         in   asynchronous active-high reset
//   left_in       in   left sample, two's complement
//   right_in      in   right sample, two's complement
//   sample_valid  in   pair presented
//   sample_ready  out  holding register empty
//   underrun      out  1-cycle pulse: frame started without a new pair
//   frame_start   out  1-cycle pulse: frame loaded
//   AUD_BCK       out  bit clock
//   AUD_LRCK      out  word clock, 0 = left
//   AUD_DACDAT    out  serial data, changes only on BCK fall
module i2s_audioout
  import audio_pkg::*;
#(
  parameter int BCK_HALF    = BCK_HALF_DEFAULT,
  parameter int BITS_PER_CH = BITS_PER_CH_DEFAULT,
  parameter int DATA_DELAY  = 1
) (
  input  logic                   AUD_XCK,
  input  logic                   reset,
  input  logic [BITS_PER_CH-1:0] left_in,
  input  logic [BITS_PER_CH-1:0] right_in,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  output logic                   underrun,
  output logic                   frame_start,
  output logic                   AUD_BCK,
  output logic                   AUD_LRCK,
  output logic                   AUD_DACDAT
);

  localparam int FRAME_W = 2 * BITS_PER_CH;
  localparam int SLOT_W  = $clog2(FRAME_W);

  logic               fall_evt;
  logic [SLOT_W-1:0]  slot_cnt;
  logic               frame_load;
  logic               accept;
  logic               full;
  logic [FRAME_W-1:0] hold_frame;
  logic [FRAME_W-1:0] last_frame;
  logic [FRAME_W-1:0] shift_reg;
  logic [FRAME_W-1:0] next_frame;
  logic [FRAME_W-1:0] shift_src;

  i2s_clkgen #(
    .BCK_HALF    (BCK_HALF),
    .BITS_PER_CH (BITS_PER_CH)
  ) u_clkgen (
    .AUD_XCK  (AUD_XCK),
    .reset    (reset),
    .bck      (AUD_BCK),
    .lrck     (AUD_LRCK),
    .fall_evt (fall_evt),
    .slot_cnt (slot_cnt)
  );

  // The load happens on the fall event that wraps slot_cnt back to 0.
  assign frame_load   = fall_evt && (slot_cnt == SLOT_W'(FRAME_W - 1));
  assign sample_ready = !full;
  assign accept       = sample_valid && sample_ready;
  // Decision uses the registered full: a pair accepted on the load edge
  // itself is too late for this frame and waits in holding for the next.
  assign next_frame   = full ? hold_frame : last_frame;

  // NOTE: always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    shift_src = shift_reg;
    if (frame_load) begin
      shift_src = next_frame;
    end
  end

  always_ff @(posedge AUD_XCK or posedge reset) begin
    if (reset) begin
      // NOTE: the data registers are cleared as well, so the frame running
      // at reset release and any repeated frame before the first pair are
      // guaranteed silent rather than stale.
      full        <= 1'b0;
      hold_frame  <= '0;
      last_frame  <= '0;
      shift_reg   <= '0;
      AUD_DACDAT  <= 1'b0;
      underrun    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;

      // accept only happens while full is low, so it never competes with
      // the clear below.
      if (accept) begin
        hold_frame <= {left_in, right_in};
        full       <= 1'b1;
      end else if (frame_load && full) begin
        full <= 1'b0;
      end

      if (frame_load) begin
        frame_start <= 1'b1;
        underrun    <= !full;
        if (full) begin
          last_frame <= hold_frame;
        end
      end

      if (fall_evt) begin
        if (DATA_DELAY != 0) begin
          // Output lags the register by one slot: at the load edge the
          // outgoing frame's last bit (right LSB) is still at the top.
          AUD_DACDAT <= shift_reg[FRAME_W-1];
          shift_reg  <= frame_load ? next_frame : (shift_reg << 1);
        end else begin
          AUD_DACDAT <= shift_src[FRAME_W-1];
          shift_reg  <= shift_src << 1;
        end
      end
    end
  end

endmodule
